// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU select codes, opcode/funct values and
// small lookup helpers used by the issue stage and the ALU.
package mips_pkg;

  typedef enum logic [4:0] {
    ALU_SHL   = 5'h00,
    ALU_SHR   = 5'h01,
    ALU_MUL   = 5'h02,
    ALU_MULU  = 5'h03,
    ALU_DIV   = 5'h04,
    ALU_DIVU  = 5'h05,
    ALU_ADD   = 5'h06,
    ALU_ADDU  = 5'h07,
    ALU_SUB   = 5'h08,
    ALU_SUBU  = 5'h09,
    ALU_AND   = 5'h0A,
    ALU_OR    = 5'h0B,
    ALU_XOR   = 5'h0C,
    ALU_NOR   = 5'h0D,
    ALU_SLT   = 5'h0E,
    ALU_SLTU  = 5'h0F,
    ALU_PASSB = 5'h10
  } alu_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam int MULDIV_CYCLES_DEFAULT = 4;

  // ALU code for a register-register funct (only meaningful for decodable functs)
  function automatic alu_sel_e rtype_sel(input logic [5:0] funct);
    case (funct)
      F_MULT:  return ALU_MUL;
      F_MULTU: return ALU_MULU;
      F_DIV:   return ALU_DIV;
      F_DIVU:  return ALU_DIVU;
      F_ADD:   return ALU_ADD;
      F_ADDU:  return ALU_ADDU;
      F_SUB:   return ALU_SUB;
      F_SUBU:  return ALU_SUBU;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SLTU:  return ALU_SLTU;
      default: return ALU_SHL;
    endcase
  endfunction

  // ALU code for an immediate-form arithmetic/logic opcode
  function automatic alu_sel_e itype_sel(input logic [5:0] opcode);
    case (opcode)
      OP_ADDI:  return ALU_ADD;
      OP_ADDIU: return ALU_ADDU;
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      default:  return ALU_SHL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: instruction word to ALU select, operand muxes,
// writeback target and mul/div / illegal classification.
module alu_decode import mips_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [4:0]       alu_sel,
  output logic [WIDTH-1:0] a_val,
  output logic [WIDTH-1:0] b_val,
  output logic [4:0]       dest,
  output logic             wb_en,
  output logic             is_muldiv,
  output logic             illegal
);

  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic [4:0]       rt_s;
  logic [4:0]       rd_s;
  logic [15:0]      imm_s;
  logic [WIDTH-1:0] shamt_ext_s;
  logic [WIDTH-1:0] imm_sx_s;
  logic [WIDTH-1:0] imm_zx_s;
  logic [WIDTH-1:0] imm_hi_s;
  alu_sel_e         sel_s;
  logic [4:0]       dest_s;
  logic             wb_s;
  logic             unused_rs_field_s;

  assign opcode_s    = instr[31:26];
  assign rt_s        = instr[20:16];
  assign rd_s        = instr[15:11];
  assign funct_s     = instr[5:0];
  assign imm_s       = instr[15:0];
  assign shamt_ext_s = WIDTH'(instr[10:6]);
  assign imm_sx_s    = WIDTH'($signed(imm_s));
  assign imm_zx_s    = WIDTH'(imm_s);
  assign imm_hi_s    = WIDTH'({imm_s, 16'h0000});

  // rs operand arrives already read from the register file
  assign unused_rs_field_s = ^instr[25:21];

  // Field decode: every path sets all outputs, unknown encodings flag illegal
  always_comb begin
    sel_s     = ALU_SHL;
    a_val     = '0;
    b_val     = '0;
    dest_s    = 5'd0;
    wb_s      = 1'b0;
    is_muldiv = 1'b0;
    illegal   = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_SLL: begin
            sel_s = ALU_SHL; a_val = rt_val; b_val = shamt_ext_s;
            dest_s = rd_s; wb_s = 1'b1;
          end
          F_SRL: begin
            // ALU shifter computes B >> A, so the amount goes on A
            sel_s = ALU_SHR; a_val = shamt_ext_s; b_val = rt_val;
            dest_s = rd_s; wb_s = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            sel_s = rtype_sel(funct_s); a_val = rs_val; b_val = rt_val;
            is_muldiv = 1'b1;
          end
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            sel_s = rtype_sel(funct_s); a_val = rs_val; b_val = rt_val;
            dest_s = rd_s; wb_s = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        sel_s = itype_sel(opcode_s); a_val = rs_val; b_val = imm_sx_s;
        dest_s = rt_s; wb_s = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        sel_s = itype_sel(opcode_s); a_val = rs_val; b_val = imm_zx_s;
        dest_s = rt_s; wb_s = 1'b1;
      end
      OP_LUI: begin
        sel_s = ALU_PASSB; b_val = imm_hi_s;
        dest_s = rt_s; wb_s = 1'b1;
      end
      OP_LW: begin
        sel_s = ALU_ADDU; a_val = rs_val; b_val = imm_sx_s;
        dest_s = rt_s; wb_s = 1'b1;
      end
      OP_SW: begin
        sel_s = ALU_ADDU; a_val = rs_val; b_val = imm_sx_s;
      end
      OP_BEQ, OP_BNE: begin
        // EX resolves the branch from the Zero flag of rs - rt
        sel_s = ALU_SUBU; a_val = rs_val; b_val = rt_val;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_sel = sel_s;
  assign dest    = dest_s;
  // Writes to $0 are discarded, so never request them
  assign wb_en   = wb_s & (dest_s != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes one instruction per cycle into an ID/EX register
// with valid/stall/flush handshake, and blocks the front end while a
// multi-cycle mul/div occupies EX.
module alu_issue import mips_pkg::*; #(
  parameter int WIDTH         = 32,
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [4:0]       alu_sel,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [4:0]       dest_reg,
  output logic             wb_en,
  output logic             illegal
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;
  localparam logic [7:0] MD_LOAD    = 8'(MULDIV_CYCLES - 1);
  localparam bit         MD_MULTI   = (MULDIV_CYCLES > 1);

  logic [0:0]       state_r;
  logic [7:0]       md_cnt_r;
  logic             out_valid_r;
  logic [4:0]       alu_sel_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [4:0]       dest_r;
  logic             wb_en_r;
  logic             illegal_r;

  logic [4:0]       dec_sel_s;
  logic [WIDTH-1:0] dec_a_s;
  logic [WIDTH-1:0] dec_b_s;
  logic [4:0]       dec_dest_s;
  logic             dec_wb_s;
  logic             dec_muldiv_s;
  logic             dec_illegal_s;
  logic             hold_s;
  logic             accept_s;

  alu_decode #(.WIDTH(WIDTH)) u_decode (
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .alu_sel   (dec_sel_s),
    .a_val     (dec_a_s),
    .b_val     (dec_b_s),
    .dest      (dec_dest_s),
    .wb_en     (dec_wb_s),
    .is_muldiv (dec_muldiv_s),
    .illegal   (dec_illegal_s)
  );

  assign hold_s   = out_valid_r & ex_stall;
  assign in_ready = (state_r == ST_IDLE) & ~hold_s;
  // A redirect kills the incoming op as well as the held one
  assign accept_s = in_valid & in_ready & ~flush;

  // ID/EX register: flush beats stall, stall holds everything, else load or bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      alu_sel_r   <= 5'd0;
      a_r         <= '0;
      b_r         <= '0;
      dest_r      <= 5'd0;
      wb_en_r     <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (hold_s) begin
      out_valid_r <= out_valid_r;
      illegal_r   <= illegal_r;
    end else if (accept_s && dec_illegal_s) begin
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b1;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      alu_sel_r   <= dec_sel_s;
      a_r         <= dec_a_s;
      b_r         <= dec_b_s;
      dest_r      <= dec_dest_s;
      wb_en_r     <= dec_wb_s;
      illegal_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end
  end

  // Mul/div occupancy: count remaining EX cycles, frozen while EX stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      md_cnt_r <= 8'd0;
    end else if (flush) begin
      state_r  <= ST_IDLE;
      md_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !dec_illegal_s && dec_muldiv_s && MD_MULTI) begin
            state_r  <= ST_MD_WAIT;
            md_cnt_r <= MD_LOAD;
          end else begin
            state_r  <= ST_IDLE;
            md_cnt_r <= 8'd0;
          end
        end
        ST_MD_WAIT: begin
          if (ex_stall) begin
            md_cnt_r <= md_cnt_r;
          end else if (md_cnt_r <= 8'd1) begin
            state_r  <= ST_IDLE;
            md_cnt_r <= 8'd0;
          end else begin
            md_cnt_r <= md_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          md_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign alu_sel   = alu_sel_r;
  assign a_out     = a_r;
  assign b_out     = b_r;
  assign dest_reg  = dest_r;
  assign wb_en     = wb_en_r;
  assign illegal   = illegal_r;

endmodule
